// File: rtl/ecc_secded_pkg.sv
// Shared definitions for the 39-bit SECDED (32 data + 6 check + 1 parity) decoder path.
package ecc_secded_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int CODE_WIDTH = 39;
    localparam int SYN_WIDTH  = 6;

    // Index 0 is overall parity; powers of two are Hamming check bits.
    function automatic logic is_check_pos(input int i);
        return (i == 0) || ((i & (i - 1)) == 0);
    endfunction

    // Codeword index that carries data bit j (data fills non-check indices in ascending order).
    function automatic int data_pos(input int j);
        int cnt = 0;
        int pos = 0;
        for (int i = 1; i < CODE_WIDTH; i++) begin
            if (!is_check_pos(i)) begin
                if (cnt == j) pos = i;
                cnt++;
            end
        end
        return pos;
    endfunction

    // Stage 1: raw codeword plus its decode terms.
    typedef struct packed {
        logic [CODE_WIDTH-1:0] code;
        logic [SYN_WIDTH-1:0]  syn;
        logic                  p;
        logic                  valid;
    } s1_t;

    // Stage 2: corrected payload plus the terms that classify it.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [SYN_WIDTH-1:0]  syn;
        logic                  p;
        logic                  valid;
    } s2_t;

endpackage

// File: rtl/ecc_syndrome_calc.sv
// Combinational syndrome and overall-parity generator for one codeword.
module ecc_syndrome_calc
    import ecc_secded_pkg::*;
(
    input  logic [CODE_WIDTH-1:0] code,
    output logic [SYN_WIDTH-1:0]  syn,
    output logic                  p
);

    // Syndrome is the XOR of all set indices 1..38; p is parity over every bit.
    always_comb begin
        syn = '0;
        for (int i = 1; i < CODE_WIDTH; i++) begin
            if (code[i]) syn = syn ^ SYN_WIDTH'(i);
        end
        p = ^code;
    end

endmodule

// File: rtl/ecc_secded_decoder_pipe.sv
// Two-stage SECDED decoder: stage 1 registers syndrome/parity, stage 2 holds the
// corrected word. Also keeps saturating CE/UE counters and a sticky first-error log.
module ecc_secded_decoder_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int CODE_WIDTH = 39,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CODE_WIDTH-1:0] in_code,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_ce,
    output logic                  out_ue,
    output logic [5:0]            out_err_pos,
    output logic [CNT_WIDTH-1:0]  ce_count,
    output logic [CNT_WIDTH-1:0]  ue_count,
    input  logic                  cnt_clear,
    output logic                  log_valid,
    output logic [5:0]            log_syndrome,
    output logic                  log_overall,
    output logic                  log_ue,
    input  logic                  log_clear
);
    import ecc_secded_pkg::*;

    localparam logic [SYN_WIDTH-1:0] MAX_POS = SYN_WIDTH'(CODE_WIDTH - 1);

    // Handshake: a word transfers on a rising edge where valid && ready. A producer
    // holds valid and its payload until that edge; ready may depend on downstream
    // ready combinationally, valid never depends on ready.

    logic [SYN_WIDTH-1:0]  in_syn;
    logic                  in_p;
    s1_t                   s1;
    s2_t                   s2;
    logic                  s2_adv;
    logic                  out_hs;
    logic [CODE_WIDTH-1:0] s1_fixed;
    logic [DATA_WIDTH-1:0] s1_data;

    ecc_syndrome_calc u_syn (
        .code (in_code),
        .syn  (in_syn),
        .p    (in_p)
    );

    assign s2_adv   = !s2.valid || out_ready;
    assign in_ready = !s1.valid || s2_adv;
    assign out_hs   = s2.valid && out_ready;

    // Flip the indicated bit on a single error (index 0 touches only parity), then extract payload.
    always_comb begin
        s1_fixed = s1.code;
        if (s1.p && (s1.syn <= MAX_POS)) s1_fixed[s1.syn] = ~s1.code[s1.syn];
        s1_data = '0;
        for (int j = 0; j < DATA_WIDTH; j++) begin
            s1_data[j] = s1_fixed[SYN_WIDTH'(data_pos(j))];
        end
    end

    // Stage 1 register: loads whenever it is empty or draining into stage 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
        end else if (in_ready) begin
            s1.valid <= in_valid;
            if (in_valid) begin
                s1.code <= in_code;
                s1.syn  <= in_syn;
                s1.p    <= in_p;
            end
        end
    end

    // Stage 2 register: holds while the output is stalled so out_* stay stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2 <= '0;
        end else if (s2_adv) begin
            s2.valid <= s1.valid;
            if (s1.valid) begin
                s2.data <= s1_data;
                s2.syn  <= s1.syn;
                s2.p    <= s1.p;
            end
        end
    end

    // Classify the word in stage 2.
    always_comb begin
        out_valid   = s2.valid;
        out_data    = s2.data;
        out_ce      = s2.p && (s2.syn <= MAX_POS);
        out_ue      = (s2.p && (s2.syn > MAX_POS)) || (!s2.p && (s2.syn != '0));
        out_err_pos = out_ce ? s2.syn : '0;
    end

    // Saturating error counters; a clear overrides an increment in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ce_count <= '0;
            ue_count <= '0;
        end else if (cnt_clear) begin
            ce_count <= '0;
            ue_count <= '0;
        end else if (out_hs) begin
            if (out_ce && (ce_count != '1)) ce_count <= ce_count + CNT_WIDTH'(1);
            if (out_ue && (ue_count != '1)) ue_count <= ue_count + CNT_WIDTH'(1);
        end
    end

    // Sticky first-error log; a clear overrides a capture in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            log_valid    <= 1'b0;
            log_syndrome <= '0;
            log_overall  <= 1'b0;
            log_ue       <= 1'b0;
        end else if (log_clear) begin
            log_valid    <= 1'b0;
            log_syndrome <= '0;
            log_overall  <= 1'b0;
            log_ue       <= 1'b0;
        end else if (out_hs && (out_ce || out_ue) && !log_valid) begin
            log_valid    <= 1'b1;
            log_syndrome <= s2.syn;
            log_overall  <= s2.p;
            log_ue       <= out_ue;
        end
    end

endmodule

// File: tb/tb_ecc_secded_decoder_pipe.sv
// Directed bench for the SECDED decoder pipe with a scoreboard of expected output words.
module tb_ecc_secded_decoder_pipe;

    localparam int W = 40;  // {data[31:0], ce, ue, err_pos[5:0]}

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [38:0] in_code;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_ce;
    logic        out_ue;
    logic [5:0]  out_err_pos;
    logic [3:0]  ce_count;
    logic [3:0]  ue_count;
    logic        cnt_clear;
    logic        log_valid;
    logic [5:0]  log_syndrome;
    logic        log_overall;
    logic        log_ue;
    logic        log_clear;

    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    ecc_secded_decoder_pipe #(.DATA_WIDTH(32), .CODE_WIDTH(39), .CNT_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ce(out_ce), .out_ue(out_ue), .out_err_pos(out_err_pos),
        .ce_count(ce_count), .ue_count(ue_count), .cnt_clear(cnt_clear),
        .log_valid(log_valid), .log_syndrome(log_syndrome), .log_overall(log_overall),
        .log_ue(log_ue), .log_clear(log_clear)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit is_pow2(input int i);
        return (i > 0) && ((i & (i - 1)) == 0);
    endfunction

    function automatic logic [38:0] encode(input logic [31:0] d);
        logic [38:0] c = '0;
        int j = 0;
        logic par;
        for (int i = 1; i < 39; i++) begin
            if (!is_pow2(i)) begin
                c[i] = d[j];
                j++;
            end
        end
        for (int k = 0; k < 6; k++) begin
            par = 1'b0;
            for (int i = 1; i < 39; i++) begin
                if ((((i >> k) & 1) == 1) && (i != (1 << k))) par = par ^ c[i];
            end
            c[1 << k] = par;
        end
        c[0] = ^c[38:1];
        return c;
    endfunction

    function automatic logic [31:0] extract(input logic [38:0] c);
        logic [31:0] d = '0;
        int j = 0;
        for (int i = 1; i < 39; i++) begin
            if (!is_pow2(i)) begin
                d[j] = c[i];
                j++;
            end
        end
        return d;
    endfunction

    function automatic logic [38:0] flip(input logic [38:0] c, input int b);
        logic [38:0] r = c;
        r[b] = ~r[b];
        return r;
    endfunction

    function automatic logic [W-1:0] exp_word(input logic [31:0] d, input logic ce,
                                              input logic ue, input logic [5:0] pos);
        return {d, ce, ue, pos};
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Scoreboard: compare each delivered word against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", {out_data, out_ce, out_ue, out_err_pos}, '1);
            end else begin
                check("out_word", {out_data, out_ce, out_ue, out_err_pos}, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [38:0] code, input logic [W-1:0] exp);
        int n = 0;
        in_code  = code;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_accept", in_ready, 1);
        if (in_ready) begin
            @(posedge clk);
            exp_q.push_back(exp);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("drain", exp_q.size(), 0);
        tick();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] d0, d1, d2, d3, dr;
        logic [38:0] c0, c, c1, c2, c3;
        int b;

        rst = 1'b1; in_valid = 1'b0; in_code = '0; out_ready = 1'b1;
        cnt_clear = 1'b0; log_clear = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_data", out_data, 0);
        check("rst_flags", {out_ce, out_ue, out_err_pos}, 0);
        check("rst_counts", {ce_count, ue_count}, 0);
        check("rst_log", {log_valid, log_syndrome, log_overall, log_ue}, 0);

        // Clean word, with two-cycle latency check
        d0 = 32'hDEADBEEF;
        c0 = encode(d0);
        send(c0, exp_word(d0, 1'b0, 1'b0, 6'd0));
        check("lat_cycle1", out_valid, 0);
        tick();
        check("lat_cycle2", out_valid, 1);
        wait_drain();
        check("clean_counts", {ce_count, ue_count}, 0);
        check("clean_log_valid", log_valid, 0);

        // Single error at bit 5
        send(flip(c0, 5), exp_word(d0, 1'b1, 1'b0, 6'd5));
        wait_drain();
        check("se_ce_count", ce_count, 1);
        check("se_log_valid", log_valid, 1);
        check("se_log_syn", log_syndrome, 5);
        check("se_log_overall", log_overall, 1);
        check("se_log_ue", log_ue, 0);

        // Double error at bits 3 and 10 (syndrome 9); log must stay as captured
        c = flip(flip(c0, 3), 10);
        send(c, exp_word(extract(c), 1'b0, 1'b1, 6'd0));
        wait_drain();
        check("de_ue_count", ue_count, 1);
        check("de_ce_count", ce_count, 1);
        check("de_log_syn", log_syndrome, 5);
        check("de_log_ue", log_ue, 0);

        // Error on the overall parity bit only: corrected, payload unchanged
        send(flip(c0, 0), exp_word(d0, 1'b1, 1'b0, 6'd0));
        // Three flips (0, 8, 32): p=1 with syndrome 40 is out of range -> uncorrectable
        send(flip(flip(flip(c0, 0), 8), 32), exp_word(d0, 1'b0, 1'b1, 6'd0));
        // Single error on the top index
        send(flip(c0, 38), exp_word(d0, 1'b1, 1'b0, 6'd38));
        wait_drain();
        check("edge_ce_count", ce_count, 3);
        check("edge_ue_count", ue_count, 2);

        // Backpressure: three words with out_ready low for four cycles
        d1 = $urandom; d2 = $urandom; d3 = $urandom;
        c1 = encode(d1); c2 = encode(d2); c3 = encode(d3);
        out_ready = 1'b0;
        send(c1, exp_word(d1, 1'b0, 1'b0, 6'd0));
        send(c2, exp_word(d2, 1'b0, 1'b0, 6'd0));
        in_code  = c3;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_in_ready_low", in_ready, 0);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_data", out_data, d1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_in_ready_high", in_ready, 1);
        @(posedge clk);
        exp_q.push_back(exp_word(d3, 1'b0, 1'b0, 6'd0));
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_stream_2", out_valid, 1);
        @(negedge clk);
        check("bp_stream_3", out_valid, 1);
        wait_drain();
        check("bp_counts", {ce_count, ue_count}, {4'd3, 4'd2});

        // Saturation: 17 random single-error words drive ce_count to all-ones
        for (int i = 0; i < 17; i++) begin
            dr = $urandom;
            b  = $urandom_range(38, 1);
            send(flip(encode(dr), b), exp_word(dr, 1'b1, 1'b0, 6'(b)));
        end
        wait_drain();
        check("sat_ce_count", ce_count, 15);

        // cnt_clear coincident with an increment: clear wins
        send(flip(c0, 7), exp_word(d0, 1'b1, 1'b0, 6'd7));
        tick();
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        check("clr_hs_done", exp_q.size(), 0);
        check("clr_ce_count", ce_count, 0);
        check("clr_ue_count", ue_count, 0);
        send(flip(c0, 12), exp_word(d0, 1'b1, 1'b0, 6'd12));
        wait_drain();
        check("post_clr_ce_count", ce_count, 1);

        // Log clear alone, then clear coincident with a capture, then a fresh capture
        log_clear = 1'b1;
        tick();
        log_clear = 1'b0;
        check("logclr_valid", log_valid, 0);
        c = flip(flip(c0, 3), 10);
        send(c, exp_word(extract(c), 1'b0, 1'b1, 6'd0));
        tick();
        log_clear = 1'b1;
        tick();
        log_clear = 1'b0;
        check("logclr_win", log_valid, 0);
        c = flip(flip(c0, 6), 17);
        send(c, exp_word(extract(c), 1'b0, 1'b1, 6'd0));
        wait_drain();
        check("log2_valid", log_valid, 1);
        check("log2_syn", log_syndrome, 23);
        check("log2_overall", log_overall, 0);
        check("log2_ue", log_ue, 1);
        check("log2_ue_count", ue_count, 2);

        // Asynchronous reset with two words in flight
        out_ready = 1'b0;
        send(flip(c0, 9), exp_word(d0, 1'b1, 1'b0, 6'd9));
        send(c1, exp_word(d1, 1'b0, 1'b0, 6'd0));
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_in_ready", in_ready, 1);
        check("arst_counts", {ce_count, ue_count}, 0);
        check("arst_log", {log_valid, log_syndrome, log_overall, log_ue}, 0);
        check("arst_out", {out_data, out_ce, out_ue, out_err_pos}, 0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("arst_no_output", out_valid, 0);
        end
        tick();
        send(c2, exp_word(d2, 1'b0, 1'b0, 6'd0));
        wait_drain();
        check("final_q_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
